obj_scheduler: RTL

OBJ_SCHEDULER -- requirements
Module: obj_scheduler

---
 rtl/obj_scheduler_pkg.sv | 33 +++
 rtl/obj_scheduler_free_slot_enc.sv | 22 ++
 rtl/obj_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/obj_scheduler_pkg.sv
// Shared object-word layout and screen constants for the object scheduler.
package obj_scheduler_pkg;

  localparam int OBJ_W         = 26;
  localparam int VPOS_LSB      = 0;
  localparam int VPOS_W        = 10;
  localparam int HPOS_LSB      = 10;
  localparam int HPOS_W        = 11;
  localparam int TYPE_LSB      = 21;
  localparam int TYPE_W        = 2;
  localparam int FRAME_LSB     = 23;
  localparam int FRAME_W       = 3;
  localparam int SPAWN_HPOS    = 1023;
  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;

  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic [TYPE_W-1:0]  kind;
    logic [HPOS_W-1:0]  hpos;
    logic [VPOS_W-1:0]  vpos;
  } obj_t;

  function automatic obj_t new_obj(input logic [TYPE_W-1:0] kind, input logic [VPOS_W-1:0] vpos);
    obj_t o;
    o.frame = '0;
    o.kind  = kind;
    o.hpos  = HPOS_W'(SPAWN_HPOS);
    o.vpos  = vpos;
    return o;
  endfunction

endpackage

// File: rtl/obj_scheduler_free_slot_enc.sv
// Lowest-zero priority encoder over the slot active mask.
module free_slot_enc #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     active,
  output logic [IDX_W-1:0] idx,
  output logic             any_free
);

  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!active[i]) begin
        idx      = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obj_scheduler.sv
// Per-frame object sweep: scrolls live objects left, retires off-screen ones, accepts spawns.
module obj_scheduler
  import obj_scheduler_pkg::*;
#(
  parameter int N_OBJ         = 5,
  parameter int FRAME_DIV_LOG = 3,
  parameter int SPEED_W       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic [SPEED_W-1:0]     speed,
  input  logic                   spawn_valid,
  input  logic [1:0]             spawn_type,
  input  logic [9:0]             spawn_vpos,
  output logic                   spawn_ready,
  output logic [OBJ_W*N_OBJ-1:0] obj_flat,
  output logic [N_OBJ-1:0]       active,
  output logic                   busy,
  output logic                   frame_tick
);

  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  logic [0:0]               state;
  logic [IDX_W-1:0]         sweep_idx;
  logic [FRAME_DIV_LOG-1:0] div;
  logic                     vsync_prev;
  logic                     pending;
  logic                     anim;
  logic                     anim_pend;
  obj_t                     slots [N_OBJ];

  logic [IDX_W-1:0]  free_idx;
  logic              any_free;
  logic              div_wrap;
  logic [HPOS_W-1:0] speed_ext;
  obj_t              cur;

  free_slot_enc #(.N(N_OBJ), .IDX_W(IDX_W)) u_free_slot_enc (
    .active   (active),
    .idx      (free_idx),
    .any_free (any_free)
  );

  assign spawn_ready = (state == ST_IDLE) && any_free;
  assign div_wrap    = (div == '1);
  assign speed_ext   = HPOS_W'(speed);
  assign cur         = slots[sweep_idx];

  always_comb begin
    obj_flat = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      obj_flat[OBJ_W*i +: OBJ_W] = slots[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      sweep_idx  <= '0;
      div        <= '0;
      vsync_prev <= 1'b0;
      pending    <= 1'b0;
      anim       <= 1'b0;
      anim_pend  <= 1'b0;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
      active     <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        slots[i] <= '0;
      end
    end else begin
      vsync_prev <= vsync;
      frame_tick <= vsync_prev & ~vsync;
      if (frame_tick) begin
        div <= div + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (spawn_valid && spawn_ready) begin
            slots[free_idx]  <= new_obj(spawn_type, spawn_vpos);
            active[free_idx] <= 1'b1;
          end
          // Animation is owed if this tick wraps the divider or a merged tick already did.
          if (frame_tick || pending) begin
            state     <= ST_SWEEP;
            busy      <= 1'b1;
            sweep_idx <= '0;
            pending   <= 1'b0;
            anim      <= (pending && anim_pend) || (frame_tick && div_wrap);
            anim_pend <= 1'b0;
          end
        end

        default: begin
          if (frame_tick) begin
            pending   <= 1'b1;
            anim_pend <= anim_pend | div_wrap;
          end
          if (active[sweep_idx]) begin
            if (cur.hpos >= speed_ext) begin
              slots[sweep_idx].hpos <= cur.hpos - speed_ext;
              if (anim) begin
                slots[sweep_idx].frame <= cur.frame + 1'b1;
              end
            end else begin
              slots[sweep_idx]  <= '0;
              active[sweep_idx] <= 1'b0;
            end
          end
          if (sweep_idx == LAST_IDX) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
